// File: rtl/ysyx_24110006_axi_sram.sv
// Single-port AXI4 subordinate SRAM answering single-beat LSU reads and writes
// with configurable response latency, byte-strobed writes and DECERR outside the window.
module ysyx_24110006_axi_sram #(
    parameter int unsigned DEPTH  = 1024,
    parameter logic [31:0] BASE   = 32'h8000_0000,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned WR_LAT = 1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_axi_araddr,
    input  logic        i_axi_arvalid,
    output logic        o_axi_arready,
    input  logic [3:0]  i_axi_arid,
    output logic [31:0] o_axi_rdata,
    output logic [1:0]  o_axi_rresp,
    output logic        o_axi_rvalid,
    input  logic        i_axi_rready,
    output logic        o_axi_rlast,
    output logic [3:0]  o_axi_rid,
    input  logic [31:0] i_axi_awaddr,
    input  logic        i_axi_awvalid,
    output logic        o_axi_awready,
    input  logic [3:0]  i_axi_awid,
    input  logic [31:0] i_axi_wdata,
    input  logic [3:0]  i_axi_wstrb,
    input  logic        i_axi_wvalid,
    output logic        o_axi_wready,
    output logic [1:0]  o_axi_bresp,
    output logic        o_axi_bvalid,
    input  logic        i_axi_bready,
    output logic [3:0]  o_axi_bid
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam logic [7:0]  RD_CNT = 8'(RD_LAT - 1);
    localparam logic [7:0]  WR_CNT = 8'(WR_LAT - 1);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_e;
    typedef enum logic {GNT_READ, GNT_WRITE} grant_e;

    state_e        state_q;
    grant_e        last_grant_q;
    logic [7:0]    cnt_q;
    logic [AW-1:0] idx_q;
    logic          in_range_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   rdata_q;
    logic [1:0]    rresp_q;
    logic [1:0]    bresp_q;
    logic [3:0]    rid_q;
    logic [3:0]    bid_q;
    logic          rvalid_q;
    logic          bvalid_q;

    logic [31:0]   mem [DEPTH];

    logic [31:0]   rd_off;
    logic [31:0]   wr_off;
    logic          rd_in_range;
    logic          wr_in_range;
    logic          rd_req;
    logic          wr_req;
    logic          grant_rd;
    logic          grant_wr;
    logic          mem_we;
    logic          unused_addr;

    // Wrapping subtraction pushes addresses below BASE far out of the window.
    assign rd_off      = i_axi_araddr - BASE;
    assign wr_off      = i_axi_awaddr - BASE;
    assign rd_in_range = (rd_off[31:AW+2] == '0);
    assign wr_in_range = (wr_off[31:AW+2] == '0);
    assign unused_addr = ^{rd_off[1:0], wr_off[1:0]};

    assign rd_req   = i_axi_arvalid;
    assign wr_req   = i_axi_awvalid && i_axi_wvalid;
    assign grant_rd = rd_req && (!wr_req || last_grant_q == GNT_WRITE);
    assign grant_wr = wr_req && (!rd_req || last_grant_q == GNT_READ);

    assign o_axi_arready = (state_q == IDLE) && grant_rd;
    assign o_axi_awready = (state_q == IDLE) && grant_wr;
    assign o_axi_wready  = (state_q == IDLE) && grant_wr;

    assign mem_we = (state_q == WR_WAIT) && (cnt_q == '0) && in_range_q && !i_reset;

    always_ff @(posedge i_clock) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wstrb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_WRITE;
            cnt_q        <= '0;
            idx_q        <= '0;
            in_range_q   <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
            rresp_q      <= '0;
            bresp_q      <= '0;
            rid_q        <= '0;
            bid_q        <= '0;
            rvalid_q     <= 1'b0;
            bvalid_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_rd) begin
                        idx_q      <= rd_off[AW+1:2];
                        in_range_q <= rd_in_range;
                        rid_q      <= i_axi_arid;
                        cnt_q      <= RD_CNT;
                        state_q    <= RD_WAIT;
                        if (wr_req) last_grant_q <= GNT_READ;
                    end else if (grant_wr) begin
                        idx_q      <= wr_off[AW+1:2];
                        in_range_q <= wr_in_range;
                        wdata_q    <= i_axi_wdata;
                        wstrb_q    <= i_axi_wstrb;
                        bid_q      <= i_axi_awid;
                        cnt_q      <= WR_CNT;
                        state_q    <= WR_WAIT;
                        if (rd_req) last_grant_q <= GNT_WRITE;
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == '0) begin
                        rdata_q  <= in_range_q ? mem[idx_q] : '0;
                        rresp_q  <= in_range_q ? 2'b00 : 2'b11;
                        rvalid_q <= 1'b1;
                        state_q  <= RD_RESP;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                RD_RESP: begin
                    if (i_axi_rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (cnt_q == '0) begin
                        bresp_q  <= in_range_q ? 2'b00 : 2'b11;
                        bvalid_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                WR_RESP: begin
                    if (i_axi_bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_axi_rdata  = rdata_q;
    assign o_axi_rresp  = rresp_q;
    assign o_axi_rvalid = rvalid_q;
    assign o_axi_rlast  = 1'b1;
    assign o_axi_rid    = rid_q;
    assign o_axi_bresp  = bresp_q;
    assign o_axi_bvalid = bvalid_q;
    assign o_axi_bid    = bid_q;

endmodule

// File: tb/tb_ysyx_24110006_axi_sram.sv
// Directed bench for the AXI SRAM: latency, strobes, range errors, backpressure,
// arbitration and mid-transaction reset, with hand-computed expectations.
module tb_ysyx_24110006_axi_sram;

    localparam int unsigned DEPTH  = 1024;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned WR_LAT = 1;

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        rlast;
    logic [3:0]  rid;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [3:0]  awid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  bid;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_24110006_axi_sram #(
        .DEPTH (DEPTH),
        .BASE  (BASE),
        .RD_LAT(RD_LAT),
        .WR_LAT(WR_LAT)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_axi_araddr (araddr),
        .i_axi_arvalid(arvalid),
        .o_axi_arready(arready),
        .i_axi_arid   (arid),
        .o_axi_rdata  (rdata),
        .o_axi_rresp  (rresp),
        .o_axi_rvalid (rvalid),
        .i_axi_rready (rready),
        .o_axi_rlast  (rlast),
        .o_axi_rid    (rid),
        .i_axi_awaddr (awaddr),
        .i_axi_awvalid(awvalid),
        .o_axi_awready(awready),
        .i_axi_awid   (awid),
        .i_axi_wdata  (wdata),
        .i_axi_wstrb  (wstrb),
        .i_axi_wvalid (wvalid),
        .o_axi_wready (wready),
        .o_axi_bresp  (bresp),
        .o_axi_bvalid (bvalid),
        .i_axi_bready (bready),
        .o_axi_bid    (bid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ar_issue(input string tag, input logic [31:0] addr, input logic [3:0] id);
        int i;
        araddr  = addr;
        arid    = id;
        arvalid = 1'b1;
        #1;
        i = 0;
        while (!arready && i < 50) begin
            step();
            i++;
        end
        check({tag, "_arready"}, 32'(arready), 1);
        step();
        arvalid = 1'b0;
    endtask

    task automatic aw_issue(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [3:0] id);
        int i;
        awaddr  = addr;
        awid    = id;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        #1;
        i = 0;
        while (!(awready && wready) && i < 50) begin
            step();
            i++;
        end
        check({tag, "_awready"}, 32'(awready && wready), 1);
        step();
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic r_collect(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                             input logic [3:0] exp_id, input int hold);
        int lat;
        lat = 0;
        while (!rvalid && lat < 50) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), RD_LAT);
        check({tag, "_rdata"}, rdata, exp_data);
        check({tag, "_rresp"}, 32'(rresp), 32'(exp_resp));
        check({tag, "_rid"}, 32'(rid), 32'(exp_id));
        check({tag, "_rlast"}, 32'(rlast), 1);
        for (int h = 0; h < hold; h++) begin
            araddr  = BASE;
            arvalid = 1'b1;
            step();
            check({tag, "_hold_rvalid"}, 32'(rvalid), 1);
            check({tag, "_hold_rdata"}, rdata, exp_data);
            check({tag, "_hold_rid"}, 32'(rid), 32'(exp_id));
            check({tag, "_hold_rresp"}, 32'(rresp), 32'(exp_resp));
            check({tag, "_hold_arready"}, 32'(arready), 0);
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        step();
        rready = 1'b0;
        check({tag, "_rdrop"}, 32'(rvalid), 0);
    endtask

    task automatic b_collect(input string tag, input logic [1:0] exp_resp, input logic [3:0] exp_id,
                             input int hold);
        int lat;
        lat = 0;
        while (!bvalid && lat < 50) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), WR_LAT);
        check({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
        check({tag, "_bid"}, 32'(bid), 32'(exp_id));
        for (int h = 0; h < hold; h++) begin
            awaddr  = BASE;
            awvalid = 1'b1;
            wvalid  = 1'b1;
            wstrb   = 4'h0;
            step();
            check({tag, "_hold_bvalid"}, 32'(bvalid), 1);
            check({tag, "_hold_bid"}, 32'(bid), 32'(exp_id));
            check({tag, "_hold_bresp"}, 32'(bresp), 32'(exp_resp));
            check({tag, "_hold_awready"}, 32'(awready), 0);
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        step();
        bready = 1'b0;
        check({tag, "_bdrop"}, 32'(bvalid), 0);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [3:0] id,
                      input logic [31:0] exp_data, input logic [1:0] exp_resp, input int hold);
        ar_issue(tag, addr, id);
        r_collect(tag, exp_data, exp_resp, id, hold);
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [3:0] id, input logic [1:0] exp_resp,
                      input int hold);
        aw_issue(tag, addr, data, strb, id);
        b_collect(tag, exp_resp, id, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int seen;
        rst = 1'b1;
        araddr = '0; arvalid = 1'b0; arid = '0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; awid = '0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_bvalid", 32'(bvalid), 0);
        check("rst_rdata", rdata, 0);
        check("rst_rresp", 32'(rresp), 0);
        check("rst_rid", 32'(rid), 0);
        check("rst_bresp", 32'(bresp), 0);
        check("rst_bid", 32'(bid), 0);
        check("rst_arready", 32'(arready), 0);
        check("rst_awready", 32'(awready), 0);

        wr("w_basic", 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 4'd3, 2'b00, 0);
        rd("r_basic", 32'h8000_0010, 4'd5, 32'hDEAD_BEEF, 2'b00, 0);

        wr("w_strb", 32'h8000_0010, 32'h0000_5500, 4'b0010, 4'd4, 2'b00, 0);
        rd("r_strb", 32'h8000_0010, 4'd6, 32'hDEAD_55EF, 2'b00, 0);

        wr("w_strb0", 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 4'd1, 2'b00, 0);
        rd("r_unaligned", 32'h8000_0013, 4'd2, 32'hDEAD_55EF, 2'b00, 0);

        rd("r_oor_low", 32'h7FFF_FFFC, 4'd7, 32'h0, 2'b11, 0);
        wr("w_top", 32'h8000_0FFC, 32'h1234_5678, 4'hF, 4'd8, 2'b00, 0);
        wr("w_oor_high", 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 4'd9, 2'b11, 0);
        rd("r_top", 32'h8000_0FFC, 4'd10, 32'h1234_5678, 2'b00, 0);
        rd("r_oor_high", 32'h8000_1000, 4'd11, 32'h0, 2'b11, 0);

        wr("w_bp", 32'h8000_0050, 32'h5A5A_A5A5, 4'hF, 4'd12, 2'b00, 5);
        rd("r_bp", 32'h8000_0050, 4'd13, 32'h5A5A_A5A5, 2'b00, 5);

        // reset while a read waits for its data
        ar_issue("rst_rd", 32'h8000_0050, 4'd14);
        rst = 1'b1;
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (rvalid) seen = 1;
            step();
        end
        check("rst_rd_no_rvalid", 32'(seen), 0);
        rd("rst_rd_after", 32'h8000_0010, 4'd15, 32'hDEAD_55EF, 2'b00, 0);

        // reset before a pending write commits
        wr("w_pre", 32'h8000_0040, 32'h1111_1111, 4'hF, 4'd1, 2'b00, 0);
        aw_issue("rst_wr", 32'h8000_0040, 32'h2222_2222, 4'hF, 4'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (bvalid) seen = 1;
            step();
        end
        check("rst_wr_no_bvalid", 32'(seen), 0);
        rd("rst_wr_discard", 32'h8000_0040, 4'd3, 32'h1111_1111, 2'b00, 0);

        // contention straight out of reset: read first, then write
        rst = 1'b1;
        araddr = 32'h8000_0010; arid = 4'd1; arvalid = 1'b1;
        awaddr = 32'h8000_0020; awid = 4'd2; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check("cont1_arready", 32'(arready), 1);
        check("cont1_awready", 32'(awready), 0);
        step();
        arvalid = 1'b0;
        r_collect("cont1_r", 32'hDEAD_55EF, 2'b00, 4'd1, 0);
        check("cont1_aw_next", 32'(awready && wready), 1);
        step();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        b_collect("cont1_b", 2'b00, 4'd2, 0);

        // repeated contention: grant flips to the write
        araddr = 32'h8000_0020; arid = 4'd6; arvalid = 1'b1;
        awaddr = 32'h8000_0030; awid = 4'd7; wdata = 32'h1122_3344; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        check("cont2_arready", 32'(arready), 0);
        check("cont2_awready", 32'(awready), 1);
        step();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        b_collect("cont2_b", 2'b00, 4'd7, 0);
        check("cont2_ar_next", 32'(arready), 1);
        step();
        arvalid = 1'b0;
        r_collect("cont2_r", 32'hCAFE_F00D, 2'b00, 4'd6, 0);
        rd("r_cont2_w", 32'h8000_0030, 4'd8, 32'h1122_3344, 2'b00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
